// File: rtl/wb_stage_if.sv
// MEM -> WB bus: one pipeline entry per handshake (in_valid / in_ready).
interface wb_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PC_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_mem_rdata;
    logic [REG_AW-1:0] in_waddr;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic [1:0]        in_ld_size;
    logic              in_ld_signed;
    logic [PC_W-1:0]   in_pc;

    modport master (
        output in_valid, in_result, in_mem_rdata, in_waddr, in_reg_write,
               in_mem_to_reg, in_ld_size, in_ld_signed, in_pc,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_result, in_mem_rdata, in_waddr, in_reg_write,
               in_mem_to_reg, in_ld_size, in_ld_signed, in_pc,
        output in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: WB register, load align/extend, RF write, bypass and retire counter.
// Define WB_DEBUG_TRACE_EN to add the debug_wb_* trace outputs (and keep in_pc).
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned RCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    wb_stage_if.slave         mem,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [RCNT_W-1:0] retire_cnt
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [PC_W-1:0]     debug_wb_pc,
    output logic [DATA_W/8-1:0] debug_wb_rf_wen,
    output logic [REG_AW-1:0]   debug_wb_rf_wnum,
    output logic [DATA_W-1:0]   debug_wb_rf_wdata
`endif
);

    logic              wb_valid_q;
    logic [DATA_W-1:0] result_q;
    logic [31:0]       rdata_q;
    logic [REG_AW-1:0] waddr_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic [1:0]        ld_size_q;
    logic              ld_signed_q;
    logic [RCNT_W-1:0] retire_cnt_q;

    logic              capture;
    logic              writes_rf;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;

    assign mem.in_ready = !stall;
    assign capture      = mem.in_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            result_q     <= '0;
            rdata_q      <= '0;
            waddr_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            ld_size_q    <= 2'b00;
            ld_signed_q  <= 1'b0;
        end else begin
            if (flush) begin
                wb_valid_q <= 1'b0;
            end else if (!stall) begin
                wb_valid_q <= mem.in_valid;
            end
            if (capture) begin
                result_q     <= mem.in_result;
                rdata_q      <= mem.in_mem_rdata[31:0];
                waddr_q      <= mem.in_waddr;
                reg_write_q  <= mem.in_reg_write;
                mem_to_reg_q <= mem.in_mem_to_reg;
                ld_size_q    <= mem.in_ld_size;
                ld_signed_q  <= mem.in_ld_signed;
            end
        end
    end

    // A flushed entry never counts, even if it was valid and unstalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (wb_valid_q && !stall && !flush) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    // Byte offset comes from the low address bits kept in the stored result.
    always_comb begin
        byte_sel = rdata_q[7:0];
        case (result_q[1:0])
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            2'd3:    byte_sel = rdata_q[31:24];
            default: byte_sel = rdata_q[7:0];
        endcase
        half_sel = result_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    always_comb begin
        load_val = '0;
        case (ld_size_q)
            2'b00: begin
                if (ld_signed_q) load_val = DATA_W'($signed(byte_sel));
                else             load_val = DATA_W'(byte_sel);
            end
            2'b01: begin
                if (ld_signed_q) load_val = DATA_W'($signed(half_sel));
                else             load_val = DATA_W'(half_sel);
            end
            default: begin
                if (ld_signed_q) load_val = DATA_W'($signed(rdata_q));
                else             load_val = DATA_W'(rdata_q);
            end
        endcase
    end

    // Outputs depend only on registered state (plus stall for rf_we), so they hold while stalled.
    assign writes_rf  = wb_valid_q && reg_write_q && (waddr_q != '0);
    assign rf_we      = writes_rf && !stall;
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = mem_to_reg_q ? load_val : result_q;
    assign fwd_valid  = writes_rf;
    assign fwd_addr   = rf_waddr;
    assign fwd_data   = rf_wdata;
    assign retire_cnt = retire_cnt_q;

`ifdef WB_DEBUG_TRACE_EN
    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (capture) begin
            pc_q <= mem.in_pc;
        end
    end

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = rf_we ? '1 : '0;
    assign debug_wb_rf_wnum  = waddr_q;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    logic unused_pc;
    assign unused_pc = ^mem.in_pc;
`endif

endmodule
